// File: rtl/link_receiver.sv
// link_receiver: synchronise and debounce inter-board direction lines into clean levels plus press/release strobes
// ports: clk; rst (sync, active-low); link_in raw lines; level filtered state; rise/fall one-cycle strobes;
//        changed registered OR of strobes; any_active OR of level
module link_receiver #(
  parameter int WIDTH = 10,
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] link_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic             any_active
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic [WIDTH-1:0] sync1, sync2, hit;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  // hit marks a channel whose deviation has lasted long enough to be accepted this edge
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      hit[i] = (sync2[i] != level[i]) && (cnt[i] == LAST);
      cnt_nxt[i] = (sync2[i] == level[i] || hit[i]) ? '0 : cnt[i] + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      rise <= '0;
      fall <= '0;
      changed <= 1'b0;
      cnt <= '{default: '0};
    end else begin
      sync1 <= link_in;
      sync2 <= sync1;
      level <= (level & ~hit) | (sync2 & hit);
      rise <= hit & sync2;
      fall <= hit & ~sync2;
      changed <= |hit;
      cnt <= cnt_nxt;
    end
  end
  assign any_active = |level;
endmodule

// File: tb/tb_link_receiver.sv
// tb_link_receiver: scoreboard bench for link_receiver with STABLE_CYCLES=4
module tb_link_receiver;
  localparam int W = 10;
  localparam int LAT = 6;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [W-1:0] link_in = '0;
  logic [W-1:0] level, rise, fall;
  logic changed, any_active;
  int cyc = 0;
  int tests = 0;
  int failed = 0;
  logic mon_en = 1'b0;
  typedef struct {
    int cyc;
    logic [W-1:0] r;
    logic [W-1:0] f;
    logic [W-1:0] l;
  } exp_t;
  exp_t q[$];

  link_receiver #(.WIDTH(W), .STABLE_CYCLES(4), .CNT_W(10)) dut (
    .clk(clk), .rst(rst), .link_in(link_in), .level(level), .rise(rise),
    .fall(fall), .changed(changed), .any_active(any_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        tests++;
        if (rise !== e.r || fall !== e.f || level !== e.l || changed !== 1'b1) begin
          failed++;
          $display("FAIL strobe cyc=%0d rise=%h/%h fall=%h/%h level=%h/%h changed=%b/1",
                   cyc, rise, e.r, fall, e.f, level, e.l, changed);
        end
      end else begin
        tests++;
        if (rise !== '0 || fall !== '0 || changed !== 1'b0) begin
          failed++;
          $display("FAIL quiet cyc=%0d rise=%h fall=%h changed=%b, required all 0",
                   cyc, rise, fall, changed);
        end
      end
    end
  end

  task automatic drive(input logic [W-1:0] v, input logic [W-1:0] r, input logic [W-1:0] f,
                       input logic [W-1:0] l, input bit expect_strobe);
    @(posedge clk);
    #1;
    link_in = v;
    if (expect_strobe) q.push_back('{cyc + LAT, r, f, l});
  endtask

  task automatic test_reset();
    link_in = '1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (level !== '0 || rise !== '0 || fall !== '0 || changed !== 1'b0 || any_active !== 1'b0) begin
        failed++;
        $display("FAIL reset_hold level=%h rise=%h fall=%h changed=%b any=%b, required 0",
                 level, rise, fall, changed, any_active);
      end
    end
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.push_back('{cyc + LAT, 10'h3FF, 10'h000, 10'h3FF});
    repeat (8) @(posedge clk);
    #1;
    tests++;
    if (level !== 10'h3FF || any_active !== 1'b1) begin
      failed++;
      $display("FAIL reset_release level=%h any=%b, required 3ff 1", level, any_active);
    end
  endtask

  task automatic test_rise();
    drive(10'h000, 10'h000, 10'h3FF, 10'h000, 1);
    repeat (8) @(posedge clk);
    #1;
    tests++;
    if (level !== 10'h000 || any_active !== 1'b0) begin
      failed++;
      $display("FAIL all_low level=%h any=%b, required 000 0", level, any_active);
    end
    drive(10'h004, 10'h004, 10'h000, 10'h004, 1);
    repeat (8) @(posedge clk);
    #1;
    tests++;
    if (level !== 10'h004) begin
      failed++;
      $display("FAIL rise_level level=%h, required 004", level);
    end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 4; k++) begin
      drive(10'h024, '0, '0, '0, 0);
      repeat (2) @(posedge clk);
      drive(10'h004, '0, '0, '0, 0);
    end
    repeat (8) @(posedge clk);
    #1;
    tests++;
    if (level !== 10'h004) begin
      failed++;
      $display("FAIL glitch_level level=%h, required 004", level);
    end
  endtask

  task automatic test_simultaneous();
    drive(10'h001, 10'h001, 10'h004, 10'h001, 1);
    repeat (8) @(posedge clk);
    drive(10'h080, 10'h080, 10'h001, 10'h080, 1);
    repeat (8) @(posedge clk);
    #1;
    tests++;
    if (level !== 10'h080 || any_active !== 1'b1) begin
      failed++;
      $display("FAIL simul_level level=%h any=%b, required 080 1", level, any_active);
    end
  endtask

  task automatic test_reset_mid();
    drive(10'h088, '0, '0, '0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    tests++;
    if (level !== 10'h000 || rise !== '0 || changed !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid level=%h rise=%h changed=%b, required 000 000 0", level, rise, changed);
    end
    q.push_back('{cyc + LAT, 10'h088, 10'h000, 10'h088});
    repeat (10) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    drive(10'h000, 10'h000, 10'h088, 10'h000, 1);
    repeat (8) @(posedge clk);
    #1;
    tests++;
    if (any_active !== 1'b0 || level !== 10'h000) begin
      failed++;
      $display("FAIL all_clear level=%h any=%b, required 000 0", level, any_active);
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      link_in[9] = ~link_in[9];
    end
    link_in = '0;
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (level !== 10'h000) begin
      failed++;
      $display("FAIL toggle_level level=%h, required 000", level);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    mon_en = 1'b0;
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain pending=%0d, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/link_receiver.md
Name: link_receiver

Overview:
- Master-board stage directly downstream of the slave board's per-direction sender outputs. Consumes the 10 direction lines (l_move_*, r_move_*) arriving over inter-board wires.
- Synchronises each line, rejects glitches and crosstalk with a per-channel stability filter, and presents clean levels plus one-cycle press and release strobes to game logic.
- Sits between the board-to-board pins and the master's movement/control FSMs.

Parameters:
- WIDTH, 10, number of independent link channels. Bit order: [0]=l_left, [1]=l_right, [2]=l_up, [3]=l_down, [4]=r_left, [5]=r_right, [6]=r_up, [7]=r_down, [8..9] spare.
- STABLE_CYCLES, 1000, consecutive cycles a synchronised input must differ from the current level before it is accepted. Must be >= 1.
- CNT_W, 10, stability counter width. Must satisfy 2^CNT_W > STABLE_CYCLES-1.

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- link_in  input  WIDTH  raw asynchronous lines from the slave board.
- level  output  WIDTH  filtered, debounced state per channel.
- rise  output  WIDTH  one-cycle pulse when level goes 0->1 (press).
- fall  output  WIDTH  one-cycle pulse when level goes 1->0 (release).
- changed  output  1  registered OR of (rise | fall), asserted in the same cycle as the strobes.
- any_active  output  1  OR-reduction of level; combinational from level.

Behaviour:
- Reset (rst==0 at a clk edge): sync1, sync2, level, rise, fall, changed and all counters go to 0. This holds regardless of link_in, and any qualification in progress is discarded.
- Synchroniser: per bit, sync1 <= link_in and sync2 <= sync1. Only sync2 feeds the filter.
- Per-channel filter, evaluated every edge:
  - If sync2 == level: counter <= 0.
  - Else if counter == STABLE_CYCLES-1: level <= sync2, counter <= 0, and the matching rise/fall bit pulses for exactly one cycle.
  - Else: counter <= counter + 1.
- Latency: take edge 1 as the first edge at which sync1 samples a new link_in value. level updates at edge STABLE_CYCLES+2, and rise/fall assert in that same cycle.
- Glitch rejection: a deviation on sync2 lasting fewer than STABLE_CYCLES consecutive cycles causes no level change and no strobe. Returning to the current level clears the counter, so there is no accumulation across separate glitches.
- Strobe timing:
  - rise/fall are registered and high for one cycle only.
  - They are never both high for the same bit.
  - They are deasserted on the cycle after assertion even if the input toggles again.
- Channels are fully independent. Any combination may change in the same cycle, and every qualifying bit pulses together. changed is asserted once for that cycle.
- Conflicting directions (e.g. left and right both 1) are passed through unmodified. Arbitration belongs to the consumer.
- STABLE_CYCLES==1 is the boundary case: level follows sync2 with one extra cycle (update at edge 3).
- Release from reset with link_in held high: the line is treated as a fresh 0->1 change. rise pulses at the normal latency measured from the first non-reset edge.
- Reset asserted mid-qualification: counter cleared, no strobe emitted, level stays 0 while reset is held.
- Counter never exceeds STABLE_CYCLES-1, so there is no wrap-around.

Test Plan (WIDTH=10, STABLE_CYCLES=4):
- Reset held 3 cycles with link_in=10'h3FF -> level, rise, fall, changed and any_active are all 0 throughout. After release, rise=10'h3FF for exactly one cycle at edge 6 after release, and level=10'h3FF from then on.
- link_in[2] goes 0->1 and stays -> level[2]=1 and rise[2]=1 at edge 6, changed=1 in that cycle. rise[2]=0 at edge 7. No other bit changes.
- link_in[5] high pulse lasting 3 cycles, then 0 -> level[5] stays 0, with no rise, fall or changed. Repeat the glitch 3 times with 1-cycle gaps -> still no change.
- With level[0]=1, drop link_in[0] to 0 while link_in[7] rises in the same cycle -> at edge 6, fall[0]=1, rise[7]=1 and changed=1, all in one cycle. level becomes 10'h080 and any_active=1.
- link_in[3] rises; assert rst at edge 4 for 1 cycle -> no rise[3] strobe during or after reset at the original time. Fresh rise[3] arrives 6 edges after reset release.
- Set all channels to 0 -> any_active=0 once the last fall strobe has occurred. Toggle link_in[9] every cycle for 40 cycles -> no strobes on bit 9.
